// File: rtl/jesd204_frame_align_monitor_if.sv
// Bundle of the received-lane and frame-marker signals feeding the frame alignment monitor.
interface jesd204_frame_align_monitor_if #(
  parameter int DATA_PATH_WIDTH = 4
);
  logic [8*DATA_PATH_WIDTH-1:0] in_data;
  logic [DATA_PATH_WIDTH-1:0]   in_charisk;
  logic                         in_valid;
  logic [DATA_PATH_WIDTH-1:0]   eof;
  logic                         eomf;

  modport master (output in_data, in_charisk, in_valid, eof, eomf);
  modport slave  (input  in_data, in_charisk, in_valid, eof, eomf);
endinterface

// File: rtl/jesd204_frame_align_monitor.sv
// JESD204 frame alignment monitor: checks /F/ and /A/ control characters against local frame markers.
// Optional 8-bit saturating bad-beat counter enabled by JESD204_FRAME_ALIGN_ERR_COUNTER_EN.
module jesd204_frame_align_monitor #(
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [8*DATA_PATH_WIDTH-1:0] in_data,
  input  logic [DATA_PATH_WIDTH-1:0]   in_charisk,
  input  logic                         in_valid,
  input  logic [DATA_PATH_WIDTH-1:0]   eof,
  input  logic                         eomf,
  input  logic                         cfg_disable_char_replacement,
  input  logic [3:0]                   cfg_err_threshold,
  input  logic                         ctrl_clear,
  output logic                         status_aligned,
  output logic                         status_align_err,
  output logic                         status_misalign_event,
  output logic [7:0]                   status_err_count
);

  localparam int unsigned DPW = DATA_PATH_WIDTH;

  typedef enum logic [1:0] {ST_INIT, ST_ALIGNED, ST_ERROR} state_t;

  state_t         state_q, state_d;
  logic [3:0]     bad_q, bad_d;
  logic           aligned_q, aligned_d;
  logic           align_err_q, align_err_d;
  logic           event_q, event_d;

  logic [DPW-1:0] is_f, is_a, pos_f, pos_a;
  logic           beat_err, beat_good;
  logic [4:0]     bad_inc, thr_eff;

  always_comb begin
    is_f  = '0;
    is_a  = '0;
    pos_a = '0;
    for (int unsigned i = 0; i < DPW; i++) begin
      is_f[i] = in_charisk[i] && (in_data[8*i +: 8] == 8'hFC);
      is_a[i] = in_charisk[i] && (in_data[8*i +: 8] == 8'h7C);
    end
    pos_a[DPW-1] = eomf & eof[DPW-1];
    pos_f        = eof & ~pos_a;
    // An /F/ on the A position is caught by the is_f & ~pos_f term.
    beat_err  = in_valid && (|((is_f & ~pos_f) | (is_a & ~pos_a)));
    beat_good = in_valid && !beat_err && (|(is_f | is_a));
  end

  assign bad_inc = {1'b0, bad_q} + 5'd1;
  assign thr_eff = (cfg_err_threshold == 4'd0) ? 5'd1 : {1'b0, cfg_err_threshold};

  always_comb begin
    state_d     = state_q;
    bad_d       = bad_q;
    align_err_d = align_err_q;
    event_d     = 1'b0;
    if (ctrl_clear) begin
      state_d     = ST_INIT;
      bad_d       = '0;
      align_err_d = 1'b0;
    end else if (cfg_disable_char_replacement) begin
      state_d = ST_INIT;
    end else begin
      event_d = beat_err;
      case (state_q)
        ST_INIT: begin
          if (beat_good) begin
            state_d = ST_ALIGNED;
            bad_d   = '0;
          end
        end
        ST_ALIGNED: begin
          if (beat_err) begin
            bad_d = bad_inc[3:0];
            if (bad_inc >= thr_eff) begin
              state_d     = ST_ERROR;
              align_err_d = 1'b1;
            end
          end else if (beat_good) begin
            bad_d = '0;
          end
        end
        ST_ERROR: ;
        default: state_d = ST_INIT;
      endcase
    end
    aligned_d = (state_d == ST_ALIGNED);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      bad_q       <= '0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      event_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bad_q       <= bad_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
      event_q     <= event_d;
    end
  end

  assign status_aligned        = aligned_q;
  assign status_align_err      = align_err_q;
  assign status_misalign_event = event_q;

`ifdef JESD204_FRAME_ALIGN_ERR_COUNTER_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_clear) begin
      cnt_d = '0;
    end else if (!cfg_disable_char_replacement && beat_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign status_err_count = cnt_q;
`else
  assign status_err_count = '0;
`endif

endmodule
